uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers using round-robin arbitration.
- Accepts one byte per grant through a valid/ready handshake.
- Issues a single-cycle tx_start with latched data and parity mode to uart_tx, then tracks tx_busy through the whole frame.
- A watchdog flags a serializer that never acknowledges a start.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 16, cycles allowed between tx_start and tx_busy rising before error (>=4)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_parity_mode  input  NUM_REQ  per-requester parity select (1=odd, 0=even), forwarded unchanged
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse
tx_start  output  1  start pulse to uart_tx
tx_data  output  8  byte to uart_tx
parity_mode  output  1  parity select to uart_tx
tx_busy  input  1  busy from uart_tx (rises the cycle after it samples tx_start)
grant_id  output  clog2(NUM_REQ)  index of last granted requester
arb_busy  output  1  high from grant until frame done
frame_done  output  1  one-cycle pulse when tx_busy falls after a frame
ack_err  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=0, tx_start=0, tx_data=0, parity_mode=0.
  - grant_id=0, arb_busy=0, frame_done=0, ack_err=0.
  - rr_ptr=0, ack_cnt=0, state=IDLE.
- Reset mid-frame:
  - Every output returns to its reset value on the next edge.
  - The uart_tx frame in progress is not aborted.
  - IDLE waits for tx_busy=0 before the next grant.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If any req_valid=1 and tx_busy=0, pick winner g = first set req_valid searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On that edge: tx_start<=1, req_ready[g]<=1, tx_data<=req_data[g], parity_mode<=req_parity_mode[g], grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, arb_busy<=1, state<=LAUNCH.
  - If tx_busy=1 or no req_valid, stay in IDLE with no grant.
- LAUNCH (exactly one cycle, tx_start and req_ready visible):
  - Next edge: tx_start<=0, req_ready<=0, ack_cnt<=0, state<=WAIT_ACK.
  - tx_data and parity_mode hold until the next grant.
- WAIT_ACK:
  - If tx_busy=1: state<=WAIT_DONE.
  - Else if ack_cnt==ACK_TIMEOUT-1: ack_err<=1 (one cycle), arb_busy<=0, state<=IDLE. The byte is dropped and not retried.
  - Else ack_cnt<=ack_cnt+1.
- WAIT_DONE: when tx_busy=0: frame_done<=1 (one cycle), arb_busy<=0, state<=IDLE.
- Grant latency: req_ready and tx_start are high in the same cycle, one cycle after the arbitrating IDLE cycle.
- Minimum spacing between tx_start pulses is frame length + 3 cycles.
- Handshake:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - Deasserting req_valid before being granted is legal, and that requester is skipped.
  - A req_valid change during LAUNCH/WAIT states has no effect until IDLE.
- Fairness: a requester that is continuously valid is granted within NUM_REQ frames.
- rr_ptr does not advance when there is no grant.

Test Plan:
- Single request, NUM_REQ=4: req_valid=0001, data0=0xA5, parity0=1 -> one cycle later req_ready=0001, tx_start=1, tx_data=0xA5, parity_mode=1, grant_id=0. frame_done pulses one cycle after the uart_tx model drops tx_busy.
- All valid, data i=0x10+i -> grant order 0,1,2,3,0. tx_data sequence 0x10,0x11,0x12,0x13,0x10. Exactly one req_ready bit per grant.
- Pointer skip: first grant to 2, then req_valid=0101 -> next grant is 0 (search 3,0), then 2.
- Watchdog: serializer model never raises tx_busy -> ack_err pulses exactly ACK_TIMEOUT cycles after WAIT_ACK entry. arb_busy=0 and IDLE resume, no frame_done.
- Reset mid-frame: assert rst for 1 cycle during WAIT_DONE with tx_busy still 1 -> outputs return to reset values. No grant until tx_busy=0 even with req_valid=1111. First grant afterwards goes to 0.
- Busy at idle: tx_busy=1 externally with req_valid=0010 -> no req_ready. Grant to 1 occurs the cycle after tx_busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one uart_tx serializer between
//               NUM_REQ byte producers, with a start-acknowledge watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_parity_mode,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       parity_mode,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       frame_done,
    output logic                       ack_err
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_cnt_w-1:0]   r_ack_cnt;

    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   w_rr_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0]   w_ready_nxt;
    logic                 w_start_nxt;
    logic [7:0]           w_data_nxt;
    logic                 w_par_nxt;
    logic [c_idx_w-1:0]   w_gid_nxt;
    logic                 w_arb_nxt;
    logic                 w_fd_nxt;
    logic                 w_err_nxt;

    logic                 w_any;
    logic                 w_hit_hi;
    logic [c_idx_w-1:0]   w_win_hi;
    logic [c_idx_w-1:0]   w_win_lo;
    logic [c_idx_w-1:0]   w_win;
    logic [7:0]           w_win_data;
    logic                 w_win_par;

    // Winner is the lowest valid index at or above rr_ptr, else the lowest valid overall.
    always_comb begin
        w_any    = 1'b0;
        w_hit_hi = 1'b0;
        w_win_hi = '0;
        w_win_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any    = 1'b1;
                w_win_lo = c_idx_w'(i);
                if (c_idx_w'(i) >= r_rr_ptr) begin
                    w_hit_hi = 1'b1;
                    w_win_hi = c_idx_w'(i);
                end
            end
        end
        w_win      = w_hit_hi ? w_win_hi : w_win_lo;
        w_win_data = '0;
        w_win_par  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_idx_w'(i)) begin
                w_win_data = req_data[8*i +: 8];
                w_win_par  = req_parity_mode[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_ack_cnt;
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_data_nxt  = tx_data;
        w_par_nxt   = parity_mode;
        w_gid_nxt   = grant_id;
        w_arb_nxt   = arb_busy;
        w_fd_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !tx_busy) begin
                    w_start_nxt = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        w_ready_nxt[i] = (w_win == c_idx_w'(i));
                    end
                    w_data_nxt  = w_win_data;
                    w_par_nxt   = w_win_par;
                    w_gid_nxt   = w_win;
                    w_rr_nxt    = (w_win == c_idx_w'(NUM_REQ - 1)) ? '0 : w_win + c_idx_w'(1);
                    w_arb_nxt   = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_ack_cnt == c_cnt_w'(ACK_TIMEOUT - 1)) begin
                    // Serializer never acknowledged: the byte is dropped, not retried.
                    w_err_nxt   = 1'b1;
                    w_arb_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_ack_cnt + c_cnt_w'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_fd_nxt    = 1'b1;
                    w_arb_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_ack_cnt   <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            parity_mode <= 1'b0;
            grant_id    <= '0;
            arb_busy    <= 1'b0;
            frame_done  <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_ack_cnt   <= w_cnt_nxt;
            req_ready   <= w_ready_nxt;
            tx_start    <= w_start_nxt;
            tx_data     <= w_data_nxt;
            parity_mode <= w_par_nxt;
            grant_id    <= w_gid_nxt;
            arb_busy    <= w_arb_nxt;
            frame_done  <= w_fd_nxt;
            ack_err     <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire
